// File: rtl/iob_native_responder_ram.sv
// iob_native_responder_ram
//   Responder end of the IOb native bus, backed by a word-addressed RAM.
//   The RAM has a programmable number of wait states before a request is
//   accepted, and a programmable read latency after acceptance. Typical uses
//   are a boot/scratch memory and a timing-stress target for initiators.
//
// Ports
//   clk_i     clock
//   rst_n_i   synchronous active-low reset (takes effect even when cke_i is low)
//   cke_i     clock enable; low freezes every register and the RAM
//   avalid_i  request valid, held by the initiator until accepted
//   addr_i    word address
//   wdata_i   write data
//   wstrb_i   byte strobes; nonzero = write, zero = read
//   ready_o   request accepted this cycle when avalid_i & ready_o
//   rdata_o   read data, valid while rvalid_o is high, held afterwards
//   rvalid_o  one-cycle pulse per accepted read
//
// States
//   S_IDLE   | no request in progress
//   S_WAIT   | request seen, inserting wait states (wcnt counts up to WAIT_CYCLES)
//   S_RDPEND | read accepted, lcnt counts up to READ_LAT

module iob_native_responder_ram #(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 0,
    parameter int READ_LAT    = 1
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                cke_i,
    input  logic                avalid_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    input  logic [DATA_W/8-1:0] wstrb_i,
    output logic                ready_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                rvalid_o
);

    localparam int         STRB_W = DATA_W / 8;
    localparam int         DEPTH  = 2 ** ADDR_W;
    localparam logic [3:0] WC     = 4'(WAIT_CYCLES);
    localparam logic [3:0] RL     = 4'(READ_LAT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RDPEND
    } state_t;

    state_t              state;
    logic [3:0]          wcnt;
    logic [3:0]          lcnt;
    logic [ADDR_W-1:0]   raddr;
    logic [DATA_W-1:0]   mem [0:DEPTH-1];

    logic                rd_done;
    logic                idle_like;
    logic                acc;
    logic                is_write;
    logic                start_rd;

    // The cycle carrying the rvalid_o pulse behaves exactly like IDLE, which
    // is what allows one read per cycle with no wait states and READ_LAT = 1.
    assign rd_done   = (state == S_RDPEND) && (lcnt == RL);
    assign idle_like = (state == S_IDLE) || rd_done;
    assign is_write  = |wstrb_i;
    assign acc       = avalid_i & ready_o & cke_i;
    assign start_rd  = acc & ~is_write;

    // ready_o decodes state only, never avalid_i.
    always_comb begin
        ready_o = 1'b0;
        case (state)
            S_IDLE:   ready_o = (WAIT_CYCLES == 0);
            S_WAIT:   ready_o = (wcnt == WC);
            S_RDPEND: ready_o = rd_done && (WAIT_CYCLES == 0);
            default:  ready_o = 1'b0;
        endcase
    end

    // RAM is never reset; writes are suppressed while reset is asserted.
    always_ff @(posedge clk_i) begin
        if (rst_n_i && acc && is_write) begin
            for (int k = 0; k < STRB_W; k++) begin
                if (wstrb_i[k]) begin
                    mem[addr_i][k*8 +: 8] <= wdata_i[k*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state    <= S_IDLE;
            wcnt     <= 4'd0;
            lcnt     <= 4'd0;
            raddr    <= '0;
            rvalid_o <= 1'b0;
            rdata_o  <= '0;
        end else if (cke_i) begin
            rvalid_o <= 1'b0;
            if (start_rd) begin
                state <= S_RDPEND;
                lcnt  <= 4'd1;
                raddr <= addr_i;
                if (READ_LAT == 1) begin
                    rvalid_o <= 1'b1;
                    rdata_o  <= mem[addr_i];
                end
            end else if (idle_like) begin
                if ((WAIT_CYCLES != 0) && avalid_i) begin
                    state <= S_WAIT;
                    wcnt  <= 4'd1;
                end else begin
                    state <= S_IDLE;
                end
            end else if (state == S_WAIT) begin
                // Accepted write or abandoned request both return to IDLE.
                if (!avalid_i || acc) begin
                    state <= S_IDLE;
                end else begin
                    wcnt <= wcnt + 4'd1;
                end
            end else begin
                // No write can be accepted while a read is pending, so the
                // RAM word still reflects its value at the accept edge.
                lcnt <= lcnt + 4'd1;
                if ((lcnt + 4'd1) == RL) begin
                    rvalid_o <= 1'b1;
                    rdata_o  <= mem[raddr];
                end
            end
        end
    end

endmodule

// File: tb/tb_iob_native_responder_ram.sv
module tb_iob_native_responder_ram;

    logic        clk;

    logic        d_rst_n, d_cke, d_avalid, d_ready, d_rvalid;
    logic [11:0] d_addr;
    logic [31:0] d_wdata, d_rdata;
    logic [3:0]  d_wstrb;

    logic        w_rst_n, w_cke, w_avalid, w_ready, w_rvalid;
    logic [11:0] w_addr;
    logic [31:0] w_wdata, w_rdata;
    logic [3:0]  w_wstrb;

    int n_total = 0;
    int n_pass  = 0;

    iob_native_responder_ram dut (
        .clk_i(clk), .rst_n_i(d_rst_n), .cke_i(d_cke), .avalid_i(d_avalid),
        .addr_i(d_addr), .wdata_i(d_wdata), .wstrb_i(d_wstrb),
        .ready_o(d_ready), .rdata_o(d_rdata), .rvalid_o(d_rvalid)
    );

    iob_native_responder_ram #(.WAIT_CYCLES(3), .READ_LAT(4)) dut_w (
        .clk_i(clk), .rst_n_i(w_rst_n), .cke_i(w_cke), .avalid_i(w_avalid),
        .addr_i(w_addr), .wdata_i(w_wdata), .wstrb_i(w_wstrb),
        .ready_o(w_ready), .rdata_o(w_rdata), .rvalid_o(w_rvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Default instance: one-cycle write, ready expected high in IDLE.
    task automatic d_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        d_avalid = 1'b1; d_addr = a; d_wdata = d; d_wstrb = s;
        n_total++;
        if (d_ready !== 1'b1) $display("FAIL d_write_ready got %b want 1", d_ready);
        else n_pass++;
        @(negedge clk);
        d_avalid = 1'b0; d_wstrb = 4'h0;
    endtask

    task automatic d_read(input logic [11:0] a, output logic v, output logic [31:0] data);
        @(negedge clk);
        d_avalid = 1'b1; d_addr = a; d_wstrb = 4'h0;
        @(negedge clk);
        d_avalid = 1'b0;
        v = d_rvalid; data = d_rdata;
    endtask

    // Wait-state instance: hold avalid until ready is seen, then drop it on
    // the following negedge (the first cycle after the accept edge).
    task automatic w_issue(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        bit seen = 0;
        @(negedge clk);
        w_avalid = 1'b1; w_addr = a; w_wdata = d; w_wstrb = s;
        for (int i = 0; i < 20; i++) begin
            if (w_ready === 1'b1) begin seen = 1; break; end
            @(negedge clk);
        end
        n_total++;
        if (!seen) $display("FAIL w_issue_timeout got ready=%b want 1", w_ready);
        else n_pass++;
        @(negedge clk);
        w_avalid = 1'b0; w_wstrb = 4'h0;
    endtask

    task automatic w_read(input logic [11:0] a, output logic ok, output logic [31:0] data);
        ok = 1'b0; data = '0;
        w_issue(a, 32'h0, 4'h0);
        for (int i = 0; i < 20; i++) begin
            if (w_rvalid === 1'b1) begin ok = 1'b1; data = w_rdata; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        d_rst_n = 1'b0; w_rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if (d_rvalid !== 1'b0) $display("FAIL reset_rvalid got %b want 0", d_rvalid); else n_pass++;
        n_total++;
        if (d_rdata !== 32'h0) $display("FAIL reset_rdata got %h want 00000000", d_rdata); else n_pass++;
        n_total++;
        if (d_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", d_ready); else n_pass++;
        n_total++;
        if (w_ready !== 1'b0) $display("FAIL reset_ready_wait got %b want 0", w_ready); else n_pass++;
        d_rst_n = 1'b1; w_rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        logic v; logic [31:0] data;
        d_write(12'h010, 32'hDEADBEEF, 4'hF);
        d_read(12'h010, v, data);
        n_total++;
        if (v !== 1'b1) $display("FAIL wr_rd_rvalid got %b want 1", v); else n_pass++;
        n_total++;
        if (data !== 32'hDEADBEEF) $display("FAIL wr_rd_data got %h want deadbeef", data); else n_pass++;
        @(negedge clk);
        n_total++;
        if (d_rvalid !== 1'b0) $display("FAIL wr_rd_pulse got %b want 0", d_rvalid); else n_pass++;
        n_total++;
        if (d_rdata !== 32'hDEADBEEF) $display("FAIL wr_rd_hold got %h want deadbeef", d_rdata); else n_pass++;
    endtask

    task automatic test_strobes();
        logic v; logic [31:0] data;
        d_write(12'h003, 32'h11223344, 4'hF);
        d_write(12'h003, 32'hAABBCCDD, 4'h5);
        d_read(12'h003, v, data);
        n_total++;
        if (v !== 1'b1 || data !== 32'h11BB33DD)
            $display("FAIL strobes got v=%b %h want v=1 11bb33dd", v, data);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_d [3];
        exp_d[0] = 32'h0000_0101; exp_d[1] = 32'h0000_0202; exp_d[2] = 32'h0000_0303;
        for (int i = 0; i < 3; i++) d_write(12'(i + 1), exp_d[i], 4'hF);
        @(negedge clk);
        d_avalid = 1'b1; d_wstrb = 4'h0; d_addr = 12'h001;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i < 2) d_addr = 12'(i + 2); else d_avalid = 1'b0;
            if (i < 3) begin
                n_total++;
                if (d_rvalid !== 1'b1 || d_rdata !== exp_d[i])
                    $display("FAIL b2b_%0d got v=%b %h want v=1 %h", i, d_rvalid, d_rdata, exp_d[i]);
                else n_pass++;
            end else begin
                n_total++;
                if (d_rvalid !== 1'b0) $display("FAIL b2b_end got %b want 0", d_rvalid); else n_pass++;
            end
        end
    endtask

    task automatic test_wait_latency();
        w_issue(12'h020, 32'h5A5A0001, 4'hF);
        repeat (2) @(negedge clk);
        @(negedge clk);
        w_avalid = 1'b1; w_addr = 12'h020; w_wstrb = 4'h0;
        for (int c = 0; c <= 8; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 4) w_avalid = 1'b0;
            n_total++;
            if (w_ready !== (c == 3))
                $display("FAIL lat_ready_c%0d got %b want %b", c, w_ready, (c == 3));
            else n_pass++;
            if (c >= 4) begin
                n_total++;
                if (w_rvalid !== (c == 7))
                    $display("FAIL lat_rvalid_c%0d got %b want %b", c, w_rvalid, (c == 7));
                else n_pass++;
            end
            if (c == 7) begin
                n_total++;
                if (w_rdata !== 32'h5A5A0001) $display("FAIL lat_data got %h want 5a5a0001", w_rdata);
                else n_pass++;
            end
        end
    endtask

    task automatic test_abort();
        logic ok; logic [31:0] data;
        int bad = 0;
        w_issue(12'h030, 32'h0000AAAA, 4'hF);
        @(negedge clk);
        w_avalid = 1'b1; w_addr = 12'h030; w_wdata = 32'hFFFFFFFF; w_wstrb = 4'hF;
        repeat (2) @(negedge clk);
        w_avalid = 1'b0; w_wstrb = 4'h0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (w_rvalid !== 1'b0 || w_ready !== 1'b0) bad++;
        end
        n_total++;
        if (bad != 0) $display("FAIL abort_quiet got %0d bad cycles want 0", bad); else n_pass++;
        w_read(12'h030, ok, data);
        n_total++;
        if (ok !== 1'b1 || data !== 32'h0000AAAA)
            $display("FAIL abort_nowrite got ok=%b %h want ok=1 0000aaaa", ok, data);
        else n_pass++;
    endtask

    task automatic test_reset_mid_read();
        int pulses = 0;
        w_issue(12'h020, 32'h0, 4'h0);
        @(negedge clk);
        w_rst_n = 1'b0;
        @(negedge clk);
        w_rst_n = 1'b1;
        n_total++;
        if (w_rdata !== 32'h0) $display("FAIL rstmid_rdata got %h want 00000000", w_rdata); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            if (w_rvalid === 1'b1) pulses++;
            @(negedge clk);
        end
        n_total++;
        if (pulses != 0) $display("FAIL rstmid_rvalid got %0d pulses want 0", pulses); else n_pass++;
    endtask

    task automatic test_cke();
        int first = -1;
        int pulses = 0;
        int ready_hi = 0;
        w_issue(12'h020, 32'h0, 4'h0);
        w_cke = 1'b0;
        for (int k = 5; k <= 14; k++) begin
            @(negedge clk);
            if (k == 9) w_cke = 1'b1;
            if (k < 9 && w_ready === 1'b1) ready_hi++;
            if (w_rvalid === 1'b1) begin
                pulses++;
                if (first < 0) begin
                    first = k;
                    n_total++;
                    if (w_rdata !== 32'h5A5A0001) $display("FAIL cke_data got %h want 5a5a0001", w_rdata);
                    else n_pass++;
                end
            end
        end
        n_total++;
        if (first != 12) $display("FAIL cke_delay got cycle %0d want 12", first); else n_pass++;
        n_total++;
        if (pulses != 1) $display("FAIL cke_pulses got %0d want 1", pulses); else n_pass++;
        n_total++;
        if (ready_hi != 0) $display("FAIL cke_ready got %0d high cycles want 0", ready_hi); else n_pass++;
    endtask

    initial begin
        d_rst_n = 1'b0; d_cke = 1'b1; d_avalid = 1'b0;
        d_addr = '0; d_wdata = '0; d_wstrb = '0;
        w_rst_n = 1'b0; w_cke = 1'b1; w_avalid = 1'b0;
        w_addr = '0; w_wdata = '0; w_wstrb = '0;

        test_reset();
        test_write_read();
        test_strobes();
        test_back_to_back();
        test_wait_latency();
        test_abort();
        test_reset_mid_read();
        test_cke();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
